// File: rtl/core_mem.sv
// core_mem: memory-access pipeline stage. It takes EX/MEM entries, drives a single-outstanding bus master and produces MEM/WB results.
// Optional feature: define CORE_MEM_MISALIGN_EN to trap misaligned H/W accesses. When it is undefined, the low address bits are masked.
module core_mem (
    input  logic        clk,
    input  logic        rest,
    // EX/MEM
    input  logic        em_valid,
    output logic        em_ready,
    input  logic [31:0] em_reg_data_mem_addr,
    input  logic [31:0] em_csr_data_mem_data,
    input  logic        em_mem_read,
    input  logic        em_mem_write,
    input  logic [2:0]  em_mem_op_type,
    input  logic [4:0]  em_rd,
    input  logic        em_reg_write,
    input  logic        em_reg_write_sel,
    input  logic [11:0] em_csr,
    input  logic        em_csr_write,
    // MEM/WB
    output logic        mw_valid,
    input  logic        mw_ready,
    output logic [31:0] mw_reg_data,
    output logic [4:0]  mw_rd,
    output logic        mw_reg_write,
    output logic [11:0] mw_csr,
    output logic [31:0] mw_csr_data,
    output logic        mw_csr_write,
    // bus master
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_write,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byte_en,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    // misaligned-access exception
    output logic        exc_valid,
    input  logic        exc_ready,
    output logic [31:0] exc_cause,
    output logic [31:0] exc_tval
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_EXC} state_t;

    state_t      state, state_nxt;
    logic        accept, is_mem, is_load, misaligned, rsp_take;
    logic [1:0]  off_raw, off_eff;
    logic [31:0] st_wdata, ld_data;
    logic [3:0]  st_be;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Fields latched on accept. They are used when the bus response returns.
    logic [31:0] q_alu, q_csr_data;
    logic [2:0]  q_op;
    logic [1:0]  q_off;
    logic [4:0]  q_rd;
    logic        q_reg_write, q_reg_write_sel, q_csr_write;
    logic [11:0] q_csr;

    // NOTE: em_ready is gated by rest so that it reads 0 while reset is held. The ready term alone would be 1 in IDLE.
    assign em_ready = rest & (state == S_IDLE) & (!mw_valid | mw_ready);
    assign accept   = em_valid & em_ready;
    assign is_mem   = em_mem_read | em_mem_write;
    assign is_load  = em_mem_read;
    assign off_raw  = em_reg_data_mem_addr[1:0];
    assign rsp_take = (state == S_RSP) & bus_rsp_valid;
    assign bus_req_valid = (state == S_REQ);

    // Natural alignment: H drops off[0], and W/other sizes drop both offset bits.
    // NOTE: every variable assigned in an always_comb block gets a default first, so that no latch is inferred.
    always_comb begin
        off_eff  = 2'b00;
        st_wdata = em_csr_data_mem_data;
        st_be    = 4'b1111;
        unique case (em_mem_op_type[1:0])
            2'b00: begin
                off_eff  = off_raw;
                st_wdata = {4{em_csr_data_mem_data[7:0]}};
                st_be    = 4'b0001 << off_raw;
            end
            2'b01: begin
                off_eff  = {off_raw[1], 1'b0};
                st_wdata = {2{em_csr_data_mem_data[15:0]}};
                st_be    = 4'b0011 << {off_raw[1], 1'b0};
            end
            default: ;
        endcase
    end

`ifdef CORE_MEM_MISALIGN_EN
    assign misaligned = is_mem & (off_eff != off_raw);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (accept && is_mem) state_nxt = misaligned ? S_EXC : S_REQ;
            S_REQ:  if (bus_req_ready)    state_nxt = S_RSP;
            S_RSP:  if (bus_rsp_valid)    state_nxt = S_IDLE;
            S_EXC:  if (exc_ready)        state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Load extraction uses the latched offset and size, because the bus returns the whole word.
    always_comb begin
        ld_byte = bus_rsp_rdata[{q_off, 3'b000} +: 8];
        ld_half = bus_rsp_rdata[{q_off[1], 4'b0000} +: 16];
        unique case (q_op[1:0])
            2'b00:   ld_data = {{24{~q_op[2] & ld_byte[7]}}, ld_byte};
            2'b01:   ld_data = {{16{~q_op[2] & ld_half[15]}}, ld_half};
            default: ld_data = bus_rsp_rdata;
        endcase
    end

    // NOTE: the latched fields are ordinary flops and they get a reset value. This keeps every output at 0 during reset.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            q_alu           <= '0;
            q_csr_data      <= '0;
            q_op            <= '0;
            q_off           <= '0;
            q_rd            <= '0;
            q_reg_write     <= 1'b0;
            q_reg_write_sel <= 1'b0;
            q_csr           <= '0;
            q_csr_write     <= 1'b0;
            bus_addr        <= '0;
            bus_write       <= 1'b0;
            bus_wdata       <= '0;
            bus_byte_en     <= '0;
        end else if (accept) begin
            q_alu           <= em_reg_data_mem_addr;
            q_csr_data      <= em_csr_data_mem_data;
            q_op            <= em_mem_op_type;
            q_off           <= off_eff;
            q_rd            <= em_rd;
            q_reg_write     <= em_reg_write;
            q_reg_write_sel <= em_reg_write_sel;
            q_csr           <= em_csr;
            q_csr_write     <= em_csr_write;
            if (is_mem && !misaligned) begin
                bus_addr    <= {em_reg_data_mem_addr[31:2], 2'b00};
                bus_write   <= ~is_load;
                bus_wdata   <= st_wdata;
                bus_byte_en <= is_load ? 4'b1111 : st_be;
            end
        end
    end

    // MEM/WB slot. A non-mem accept and a bus response cannot happen together: the first needs IDLE and the second needs RSP.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            mw_valid     <= 1'b0;
            mw_reg_data  <= '0;
            mw_rd        <= '0;
            mw_reg_write <= 1'b0;
            mw_csr       <= '0;
            mw_csr_data  <= '0;
            mw_csr_write <= 1'b0;
        end else if (accept && !is_mem) begin
            mw_valid     <= 1'b1;
            mw_reg_data  <= em_reg_data_mem_addr;
            mw_rd        <= em_rd;
            mw_reg_write <= em_reg_write;
            mw_csr       <= em_csr;
            mw_csr_data  <= em_csr_data_mem_data;
            mw_csr_write <= em_csr_write;
        end else if (rsp_take) begin
            mw_valid     <= 1'b1;
            mw_reg_data  <= q_reg_write_sel ? ld_data : q_alu;
            mw_rd        <= q_rd;
            mw_reg_write <= q_reg_write;
            mw_csr       <= q_csr;
            mw_csr_data  <= q_csr_data;
            mw_csr_write <= q_csr_write;
        end else if (mw_ready) begin
            mw_valid     <= 1'b0;
        end
    end

`ifdef CORE_MEM_MISALIGN_EN
    assign exc_valid = (state == S_EXC);

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            exc_cause <= '0;
            exc_tval  <= '0;
        end else if (accept && misaligned) begin
            exc_cause <= is_load ? 32'd4 : 32'd6;
            exc_tval  <= em_reg_data_mem_addr;
        end else if ((state == S_EXC) && exc_ready) begin
            exc_cause <= '0;
            exc_tval  <= '0;
        end
    end
`else
    assign exc_valid = 1'b0;
    assign exc_cause = '0;
    assign exc_tval  = '0;
`endif

endmodule

// File: tb/tb_core_mem.sv
// tb_core_mem: directed-vector bench for core_mem.
// Define CORE_MEM_MISALIGN_EN here as well as in the RTL to exercise the trapping build.
module tb_core_mem;

    logic        clk = 1'b0;
    logic        rest;
    logic        em_valid, em_ready;
    logic [31:0] em_reg_data_mem_addr, em_csr_data_mem_data;
    logic        em_mem_read, em_mem_write;
    logic [2:0]  em_mem_op_type;
    logic [4:0]  em_rd;
    logic        em_reg_write, em_reg_write_sel;
    logic [11:0] em_csr;
    logic        em_csr_write;
    logic        mw_valid, mw_ready;
    logic [31:0] mw_reg_data;
    logic [4:0]  mw_rd;
    logic        mw_reg_write;
    logic [11:0] mw_csr;
    logic [31:0] mw_csr_data;
    logic        mw_csr_write;
    logic        bus_req_valid, bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_write;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_byte_en;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        exc_valid, exc_ready;
    logic [31:0] exc_cause, exc_tval;

    int vectors     = 0;
    int miscompares = 0;

    core_mem dut (
        .clk(clk), .rest(rest),
        .em_valid(em_valid), .em_ready(em_ready),
        .em_reg_data_mem_addr(em_reg_data_mem_addr), .em_csr_data_mem_data(em_csr_data_mem_data),
        .em_mem_read(em_mem_read), .em_mem_write(em_mem_write), .em_mem_op_type(em_mem_op_type),
        .em_rd(em_rd), .em_reg_write(em_reg_write), .em_reg_write_sel(em_reg_write_sel),
        .em_csr(em_csr), .em_csr_write(em_csr_write),
        .mw_valid(mw_valid), .mw_ready(mw_ready), .mw_reg_data(mw_reg_data), .mw_rd(mw_rd),
        .mw_reg_write(mw_reg_write), .mw_csr(mw_csr), .mw_csr_data(mw_csr_data), .mw_csr_write(mw_csr_write),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
        .bus_write(bus_write), .bus_wdata(bus_wdata), .bus_byte_en(bus_byte_en),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
        .exc_valid(exc_valid), .exc_ready(exc_ready), .exc_cause(exc_cause), .exc_tval(exc_tval)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Inputs are driven 1 ns after the rising edge and outputs are sampled at the same point.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_em(input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                          input logic rw, input logic sel, input logic rd_en, input logic wr_en,
                          input logic [2:0] op, input logic [11:0] csr, input logic csr_wr);
        em_reg_data_mem_addr = addr;
        em_csr_data_mem_data = data;
        em_rd                = rd;
        em_reg_write         = rw;
        em_reg_write_sel     = sel;
        em_mem_read          = rd_en;
        em_mem_write         = wr_en;
        em_mem_op_type       = op;
        em_csr               = csr;
        em_csr_write         = csr_wr;
    endtask

    task automatic test_reset();
        rest = 1'b0;
        em_valid = 1'b0; mw_ready = 1'b1; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
        bus_rsp_rdata = '0; exc_ready = 1'b0;
        set_em('0, '0, '0, 0, 0, 0, 0, '0, '0, 0);
        #12;
        vectors++;
        if ({em_ready, mw_valid, bus_req_valid, exc_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 0000", {em_ready, mw_valid, bus_req_valid, exc_valid});
        end
        vectors++;
        if ((mw_reg_data | bus_addr | bus_wdata | exc_cause | exc_tval) !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data: got nonzero output %h", mw_reg_data | bus_addr | bus_wdata | exc_cause | exc_tval);
        end
        @(posedge clk); #1 rest = 1'b1;
        #1;
        vectors++;
        if (em_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b want 1", em_ready);
        end
    endtask

    task automatic test_alu();
        set_em(32'h0000_1234, 32'h0000_0055, 5'd5, 1, 0, 0, 0, 3'b010, 12'h300, 1);
        em_valid = 1'b1;
        step();
        em_valid = 1'b0;
        vectors++;
        if ({mw_valid, mw_reg_data, mw_rd, mw_reg_write} !== {1'b1, 32'h0000_1234, 5'd5, 1'b1}) begin
            miscompares++;
            $display("FAIL alu_result: got v=%b d=%h rd=%0d rw=%b want v=1 d=00001234 rd=5 rw=1",
                     mw_valid, mw_reg_data, mw_rd, mw_reg_write);
        end
        vectors++;
        if ({mw_csr, mw_csr_data, mw_csr_write} !== {12'h300, 32'h0000_0055, 1'b1}) begin
            miscompares++;
            $display("FAIL alu_csr: got %h/%h/%b want 300/00000055/1", mw_csr, mw_csr_data, mw_csr_write);
        end
        step();
        vectors++;
        if (mw_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL alu_drain: got mw_valid=%b want 0", mw_valid);
        end
    endtask

    task automatic run_load(input string tag, input logic [31:0] addr, input logic [2:0] op,
                            input logic [31:0] rdata, input logic [31:0] exp_data);
        set_em(addr, 32'h0, 5'd10, 1, 1, 1, 0, op, 12'h0, 0);
        em_valid = 1'b1;
        step();
        em_valid = 1'b0;
        vectors++;
        if ({bus_req_valid, bus_write, bus_byte_en, bus_addr, exc_valid} !==
            {1'b1, 1'b0, 4'b1111, addr[31:2], 2'b00, 1'b0}) begin
            miscompares++;
            $display("FAIL %s_req: got v=%b w=%b be=%b a=%h exc=%b want v=1 w=0 be=1111 a=%h exc=0",
                     tag, bus_req_valid, bus_write, bus_byte_en, bus_addr, exc_valid, {addr[31:2], 2'b00});
        end
        bus_req_ready = 1'b1;
        step();
        bus_req_ready = 1'b0;
        vectors++;
        if ({mw_valid, bus_req_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL %s_rsp_wait: got mw_valid,req=%b want 00", tag, {mw_valid, bus_req_valid});
        end
        bus_rsp_valid = 1'b1; bus_rsp_rdata = rdata;
        step();
        bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
        vectors++;
        if ({mw_valid, mw_reg_data, mw_rd, mw_reg_write} !== {1'b1, exp_data, 5'd10, 1'b1}) begin
            miscompares++;
            $display("FAIL %s_data: got v=%b d=%h rd=%0d rw=%b want v=1 d=%h rd=10 rw=1",
                     tag, mw_valid, mw_reg_data, mw_rd, mw_reg_write, exp_data);
        end
        step();
    endtask

    task automatic test_loads();
        run_load("lb",  32'h0000_1003, 3'b000, 32'h80FF_0000, 32'hFFFF_FF80);
        run_load("lbu", 32'h0000_1003, 3'b100, 32'h80FF_0000, 32'h0000_0080);
        run_load("lb0", 32'h0000_1000, 3'b000, 32'h80FF_0071, 32'h0000_0071);
        run_load("lh",  32'h0000_1002, 3'b001, 32'h80FF_0000, 32'hFFFF_80FF);
        run_load("lhu", 32'h0000_1002, 3'b101, 32'h80FF_0000, 32'h0000_80FF);
        run_load("lw",  32'h0000_1004, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    endtask

    task automatic run_store(input string tag, input logic [31:0] addr, input logic [2:0] op,
                             input logic [31:0] data, input logic [31:0] exp_wdata,
                             input logic [3:0] exp_be, input int stall);
        set_em(addr, data, 5'd0, 0, 0, 0, 1, op, 12'h0, 0);
        em_valid = 1'b1;
        step();
        em_valid = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            vectors++;
            if ({bus_req_valid, bus_write, bus_byte_en, bus_addr, bus_wdata} !==
                {1'b1, 1'b1, exp_be, addr[31:2], 2'b00, exp_wdata}) begin
                miscompares++;
                $display("FAIL %s_req[%0d]: got v=%b w=%b be=%b a=%h wd=%h want v=1 w=1 be=%b a=%h wd=%h",
                         tag, i, bus_req_valid, bus_write, bus_byte_en, bus_addr, bus_wdata,
                         exp_be, {addr[31:2], 2'b00}, exp_wdata);
            end
            if (i == stall) bus_req_ready = 1'b1;
            step();
        end
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b1;
        step();
        bus_rsp_valid = 1'b0;
        vectors++;
        if ({mw_valid, mw_reg_write, bus_req_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL %s_ack: got mw_valid,rw,req=%b want 100", tag, {mw_valid, mw_reg_write, bus_req_valid});
        end
        step();
    endtask

    task automatic test_stores();
        run_store("sh_stall", 32'h0000_2002, 3'b001, 32'hABCD_1234, 32'h1234_1234, 4'b1100, 3);
        run_store("sb",       32'h0000_2001, 3'b000, 32'h0000_00AB, 32'hABAB_ABAB, 4'b0010, 0);
        run_store("sw",       32'h0000_2008, 3'b010, 32'h0BAD_F00D, 32'h0BAD_F00D, 4'b1111, 1);
    endtask

    task automatic test_back_to_back();
        set_em(32'h0000_0011, 32'h0, 5'd1, 1, 0, 0, 0, 3'b010, 12'h0, 0);
        em_valid = 1'b1;
        mw_ready = 1'b0;
        step();
        set_em(32'h0000_0022, 32'h0, 5'd2, 1, 0, 0, 0, 3'b010, 12'h0, 0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({em_ready, mw_valid, mw_reg_data, mw_rd} !== {1'b0, 1'b1, 32'h0000_0011, 5'd1}) begin
                miscompares++;
                $display("FAIL stall[%0d]: got rdy=%b v=%b d=%h rd=%0d want rdy=0 v=1 d=00000011 rd=1",
                         i, em_ready, mw_valid, mw_reg_data, mw_rd);
            end
            step();
        end
        mw_ready = 1'b1;
        #1;
        vectors++;
        if (em_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_release_ready: got %b want 1", em_ready);
        end
        step();
        em_valid = 1'b0;
        vectors++;
        if ({mw_valid, mw_reg_data, mw_rd} !== {1'b1, 32'h0000_0022, 5'd2}) begin
            miscompares++;
            $display("FAIL stall_next: got v=%b d=%h rd=%0d want v=1 d=00000022 rd=2", mw_valid, mw_reg_data, mw_rd);
        end
        step();
        vectors++;
        if (mw_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_drain: got mw_valid=%b want 0", mw_valid);
        end
    endtask

    task automatic test_misalign();
`ifdef CORE_MEM_MISALIGN_EN
        set_em(32'h0000_3001, 32'h0, 5'd7, 1, 1, 1, 0, 3'b010, 12'h0, 0);
        em_valid = 1'b1;
        step();
        em_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({bus_req_valid, exc_valid, em_ready, mw_valid, exc_cause, exc_tval} !==
                {4'b0100, 32'd4, 32'h0000_3001}) begin
                miscompares++;
                $display("FAIL lw_exc[%0d]: got req=%b exc=%b rdy=%b mwv=%b cause=%0d tval=%h want 0 1 0 0 4 00003001",
                         i, bus_req_valid, exc_valid, em_ready, mw_valid, exc_cause, exc_tval);
            end
            step();
        end
        exc_ready = 1'b1;
        step();
        exc_ready = 1'b0;
        vectors++;
        if ({exc_valid, em_ready, mw_valid, bus_req_valid} !== 4'b0100) begin
            miscompares++;
            $display("FAIL lw_exc_done: got exc,rdy,mwv,req=%b want 0100", {exc_valid, em_ready, mw_valid, bus_req_valid});
        end
        set_em(32'h0000_4002, 32'h1, 5'd0, 0, 0, 0, 1, 3'b010, 12'h0, 0);
        em_valid = 1'b1;
        step();
        em_valid = 1'b0;
        vectors++;
        if ({bus_req_valid, exc_valid, exc_cause, exc_tval} !== {2'b01, 32'd6, 32'h0000_4002}) begin
            miscompares++;
            $display("FAIL sw_exc: got req=%b exc=%b cause=%0d tval=%h want 0 1 6 00004002",
                     bus_req_valid, exc_valid, exc_cause, exc_tval);
        end
        exc_ready = 1'b1;
        step();
        exc_ready = 1'b0;
        vectors++;
        if ({exc_valid, mw_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL sw_exc_done: got exc,mwv=%b want 00", {exc_valid, mw_valid});
        end
`else
        run_load("lw_mask", 32'h0000_3001, 3'b010, 32'hCAFE_F00D, 32'hCAFE_F00D);
        run_load("lh_mask", 32'h0000_3003, 3'b001, 32'h8001_7FFF, 32'hFFFF_8001);
        vectors++;
        if ({exc_valid, exc_cause, exc_tval} !== 65'h0) begin
            miscompares++;
            $display("FAIL exc_tied: got exc=%b cause=%h tval=%h want 0", exc_valid, exc_cause, exc_tval);
        end
`endif
    endtask

    task automatic test_reset_mid();
        set_em(32'h0000_5000, 32'h0, 5'd3, 1, 1, 1, 0, 3'b010, 12'h0, 0);
        em_valid = 1'b1;
        step();
        em_valid = 1'b0;
        bus_req_ready = 1'b1;
        step();
        bus_req_ready = 1'b0;
        #2 rest = 1'b0;
        #1;
        vectors++;
        if ({em_ready, mw_valid, bus_req_valid, bus_byte_en, bus_addr, mw_reg_data} !== 71'h0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got rdy=%b mwv=%b req=%b be=%b a=%h d=%h want all 0",
                     em_ready, mw_valid, bus_req_valid, bus_byte_en, bus_addr, mw_reg_data);
        end
        @(posedge clk); #1 rest = 1'b1;
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h1234_5678;
        step();
        bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
        vectors++;
        if ({mw_valid, bus_req_valid, em_ready} !== 3'b001) begin
            miscompares++;
            $display("FAIL late_rsp: got mwv,req,rdy=%b want 001", {mw_valid, bus_req_valid, em_ready});
        end
        step();
        vectors++;
        if (mw_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL late_rsp_hold: got mw_valid=%b want 0", mw_valid);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_stores();
        test_back_to_back();
        test_misalign();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
